// File: rtl/mem_responder.sv
// Word-addressed memory responder for the MAR/MDR port: accepts one read or write,
// inserts WAIT_STATES wait cycles, then completes with a one-cycle mem_ready pulse.
module mem_responder #(
  parameter int ADDR_BITS   = 9,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] mar_addr,
  input  logic [31:0] mdr_wdata,
  input  logic        read_req,
  input  logic        write_req,
  output logic [31:0] mdatain,
  output logic        mem_ready,
  output logic        busy,
  output logic        err
);

  localparam int         DEPTH  = 1 << ADDR_BITS;
  localparam logic [3:0] WAIT_N = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 r_state;
  logic [3:0]             r_cnt;
  logic [ADDR_BITS-1:0]   r_addr;
  logic [31:0]            r_wdata;
  logic                   r_is_write;
  logic                   r_oor;
  logic                   r_rej_pend;
  logic [31:0]            r_mdatain;
  logic                   r_mem_ready;
  logic                   r_busy;
  logic                   r_err;
  logic [31:0]            r_mem [DEPTH];

  logic w_single_req;
  logic w_both_req;
  logic w_oor;

  assign w_single_req = read_req ^ write_req;
  assign w_both_req   = read_req & write_req;
  assign w_oor        = |mar_addr[31:ADDR_BITS];

  assign mdatain   = r_mdatain;
  assign mem_ready = r_mem_ready;
  assign busy      = r_busy;
  assign err       = r_err;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_is_write  <= 1'b0;
      r_oor       <= 1'b0;
      r_rej_pend  <= 1'b0;
      r_mdatain   <= '0;
      r_mem_ready <= 1'b0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_mem_ready <= 1'b0;
      // A conflicting request is flagged one edge after it is sampled.
      r_err       <= r_rej_pend;
      r_rej_pend  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_single_req) begin
            r_addr     <= mar_addr[ADDR_BITS-1:0];
            r_wdata    <= mdr_wdata;
            r_is_write <= write_req;
            r_oor      <= w_oor;
            r_cnt      <= WAIT_N;
            r_busy     <= 1'b1;
            r_state    <= (WAIT_N == 4'd0) ? DONE : WAIT;
          end else if (w_both_req) begin
            r_rej_pend <= 1'b1;
          end
        end
        WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) r_state <= DONE;
        end
        DONE: begin
          r_mem_ready <= 1'b1;
          r_busy      <= 1'b0;
          r_err       <= r_oor;
          if (!r_is_write) r_mdatain <= r_oor ? 32'd0 : r_mem[r_addr];
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // NOTE: the array has no reset; contents survive clr and are defined by writes only.
  // An aborted access never reaches DONE, so its write is never performed.
  always_ff @(posedge clk) begin
    if (r_state == DONE && r_is_write && !r_oor) r_mem[r_addr] <= r_wdata;
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Word-addressed memory responder that serves the datapath's MAR/MDR memory port. It accepts a read or write request carrying the MAR address and MDR write data, and inserts a fixed number of wait states. It then completes the access and signals completion with a one-cycle `mem_ready` pulse; read data appears on `mdatain`, which feeds the MDR's memory-data input. It is the memory-side end of the interface driven by the datapath's MARin/MDRin/MDRread controls and the control sequencer.

## Interface
- `ADDR_BITS`, default 9: word-address width; the array holds 2^ADDR_BITS 32-bit words.
- `WAIT_STATES`, default 2: wait cycles inserted between request acceptance and completion; legal range 0..15.
- `clk`, input, 1: single clock; all state changes occur on the rising edge.
- `clr`, input, 1: reset, asynchronous, active-low.
- `mar_addr`, input, 32: word address from MAR; only bits [ADDR_BITS-1:0] index the array.
- `mdr_wdata`, input, 32: write data from MDR.
- `read_req`, input, 1: level request for a read.
- `write_req`, input, 1: level request for a write.
- `mdatain`, output, 32: read data, registered; holds its value until the next successful read.
- `mem_ready`, output, 1: one-cycle completion pulse.
- `busy`, output, 1: high while an accepted access is in flight.
- `err`, output, 1: one-cycle pulse marking a rejected or faulted access; coincides with `mem_ready` or stands alone.

## Operation
- FSM states: IDLE, WAIT, DONE. Reset state is IDLE.
- IDLE, exactly one of `read_req`/`write_req` high:
  - Latch the address, write data and operation.
  - Load the wait counter with WAIT_STATES.
  - Set `busy`.
  - Go to WAIT, or go directly to DONE if WAIT_STATES is 0.
- IDLE, both requests high:
  - The access is not accepted and nothing is written.
  - `err` pulses for one cycle and the FSM stays in IDLE.
- IDLE, neither request high: the FSM stays in IDLE.
- WAIT:
  - The counter decrements every cycle.
  - When the counter reaches 1, the next state is DONE.
  - Request inputs are ignored in WAIT; latched values are used.
- DONE, one cycle:
  - Write: array[addr] <= wdata.
  - Read: `mdatain` <= array[addr].
  - `mem_ready` = 1, `busy` = 0.
  - Next state is IDLE.
- Out-of-range address, i.e. any of `mar_addr`[31:ADDR_BITS] nonzero:
  - The access still runs the full wait sequence.
  - In DONE, `err` pulses with `mem_ready`.
  - A write is dropped.
  - A read loads `mdatain` with 0.
- In the cycle `mem_ready` is high, request inputs are not sampled. The initiator deasserts its request on seeing `mem_ready`. A request still held afterwards is accepted as a new access.
- Read-after-write to the same address returns the newly written word.
- Array contents are not cleared by reset. The bench initialises the array by writing it before reading.

## Timing
- Reset values: `mdatain` = 0, `mem_ready` = 0, `busy` = 0, `err` = 0, FSM = IDLE, wait counter = 0.
- A request is sampled at edge E0. With N = WAIT_STATES:
  - `busy` is high from E0 to E0+N+1.
  - `mem_ready`, `err` (if any) and the new `mdatain` are valid from E0+N+1 for exactly one cycle.
  - The write lands in the array at edge E0+N+1.
- The earliest next acceptance is edge E0+N+2. Sustained throughput is one access per N+2 cycles.
- A simultaneous-request `err` is valid from E0+1 for one cycle, with `busy` staying low.
- Reset asserted mid-access:
  - The FSM returns to IDLE immediately and all outputs take their reset values.
  - A pending write is not performed.
  - No `mem_ready` is issued for the aborted access.
- `mdatain` changes only at a read's DONE edge or on reset; writes never disturb it.

## Test plan
- N=2: write 0xDEADBEEF to addr 5 sampled at E0 -> `busy` high E0..E3, `mem_ready` single pulse at E3, `err` low. Then read addr 5 -> `mdatain` = 0xDEADBEEF with `mem_ready` at E0'+3.
- N=0: write 0x12345678 to addr 0x1FF, then read -> `mem_ready` one cycle after each acceptance, `mdatain` = 0x12345678. Request held high through `mem_ready` -> re-accepted at the following edge (E0+2).
- `read_req` and `write_req` both high with addr 5, wdata 0 -> `err` pulse at E0+1, no `mem_ready`, `busy` stays low; a later read of addr 5 still returns 0xDEADBEEF.
- ADDR_BITS=9: write 0xCAFEF00D to addr 0x00000200 -> `err` and `mem_ready` together at E0+N+1, addr 0 unchanged. Read 0x00001000 -> `mdatain` = 0 with `err`.
- Write 0xAAAA5555 to addr 7 with `clr` pulsed low during WAIT -> `busy`/`mem_ready`/`mdatain` = 0 immediately, no `mem_ready` for the aborted access; a subsequent read of addr 7 returns its prior value.
- Back-to-back alternating write/read of 16 sequential addresses at N=3 -> every read matches its preceding write, one `mem_ready` per access, spacing exactly 5 cycles.
